// File: rtl/detect_reporter_if.sv
// Mask-in / position-out handshake bundle for detect_reporter.
// slave is the reporter's view; master is the driver/consumer view.
interface detect_reporter_if #(
  parameter int WIDTH = 16,
  parameter int POS_W = 4,
  parameter int CNT_W = 5
);
  logic [WIDTH-1:0] mask_in;
  logic             mask_valid;
  logic             mask_ready;
  logic [POS_W-1:0] pos_out;
  logic             pos_valid;
  logic             pos_ready;
  logic [CNT_W-1:0] match_count;
  logic             count_valid;
  logic             done;
  logic             drop;

  modport slave (
    input  mask_in, mask_valid, pos_ready,
    output mask_ready, pos_out, pos_valid,
    output match_count, count_valid, done, drop
  );

  modport master (
    output mask_in, mask_valid, pos_ready,
    input  mask_ready, pos_out, pos_valid,
    input  match_count, count_valid, done, drop
  );
endinterface

// File: rtl/detect_reporter.sv
// Reports set-bit positions of a detection mask, MSB first,
// one per handshake, after registering the match count.
module detect_reporter #(
  parameter int WIDTH = 16,
  parameter int POS_W = 4,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  detect_reporter_if.slave io
);

  typedef enum logic [1:0] {
    IDLE, COUNT, EMIT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] shadow_clr;

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [POS_W-1:0] msb_idx(
    input logic [WIDTH-1:0] v
  );
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = POS_W'(i);
    return idx;
  endfunction

  // Shadow with the currently presented position removed
  assign shadow_clr = shadow_q & ~(WIDTH'(1) << pos_q);

  // Next-state and next-output logic for the report FSM
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    cnt_d       = cnt_q;
    cnt_valid_d = cnt_valid_q;
    done_d      = 1'b0;
    drop_d      = drop_q;
    if (io.mask_valid && state_q != IDLE)
      drop_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (io.mask_valid) begin
          shadow_d    = io.mask_in;
          cnt_valid_d = 1'b0;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        cnt_d       = popcnt(shadow_q);
        cnt_valid_d = 1'b1;
        if (shadow_q != '0) begin
          pos_d       = msb_idx(shadow_q);
          pos_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      EMIT: begin
        if (io.pos_ready) begin
          shadow_d = shadow_clr;
          if (shadow_clr != '0) begin
            pos_d = msb_idx(shadow_clr);
          end else begin
            pos_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      cnt_q       <= '0;
      cnt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      cnt_q       <= cnt_d;
      cnt_valid_q <= cnt_valid_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  assign io.mask_ready  = (state_q == IDLE) && !reset;
  assign io.pos_out     = pos_q;
  assign io.pos_valid   = pos_valid_q;
  assign io.match_count = cnt_q;
  assign io.count_valid = cnt_valid_q;
  assign io.done        = done_q;
  assign io.drop        = drop_q;

endmodule

// File: tb/tb_detect_reporter.sv
// Directed bench for detect_reporter.
// Inputs driven and outputs sampled 1 time unit after posedge.
module tb_detect_reporter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  detect_reporter_if #(.WIDTH(16), .POS_W(4), .CNT_W(5)) bus ();

  detect_reporter #(.WIDTH(16), .POS_W(4), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mask_valid = 1'b0;
    bus.mask_in = '0;
    bus.pos_ready = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus.mask_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mask_ready got %0b want 0", bus.mask_ready);
    end
    n_chk++;
    if ({bus.pos_out, bus.pos_valid, bus.match_count,
         bus.count_valid, bus.done, bus.drop} !== 12'h0) begin
      n_fail++;
      $display("FAIL rst_outputs got pos=%0d pv=%0b cnt=%0d cv=%0b d=%0b dr=%0b want all 0",
               bus.pos_out, bus.pos_valid, bus.match_count,
               bus.count_valid, bus.done, bus.drop);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.mask_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_mask_ready got %0b want 1", bus.mask_ready);
    end
  endtask

  task automatic test_zero();
    bus.mask_in = 16'h0000;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    n_chk++;
    if (bus.count_valid !== 1'b0 || bus.mask_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_state got cv=%0b rdy=%0b want 0 0",
               bus.count_valid, bus.mask_ready);
    end
    tick();
    n_chk++;
    if (bus.match_count !== 5'd0 || bus.count_valid !== 1'b1 ||
        bus.done !== 1'b1 || bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got cnt=%0d cv=%0b d=%0b pv=%0b want 0 1 1 0",
               bus.match_count, bus.count_valid, bus.done, bus.pos_valid);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b0 || bus.mask_ready !== 1'b1 ||
        bus.count_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_idle got d=%0b rdy=%0b cv=%0b want 0 1 1",
               bus.done, bus.mask_ready, bus.count_valid);
    end
  endtask

  task automatic test_sparse();
    int exp_pos[4] = '{15, 10, 5, 0};
    bus.pos_ready = 1'b1;
    bus.mask_in = 16'h8421;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    n_chk++;
    if (bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sparse_latency got pv=%0b want 0", bus.pos_valid);
    end
    tick();
    n_chk++;
    if (bus.match_count !== 5'd4 || bus.count_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_count got %0d cv=%0b want 4 1",
               bus.match_count, bus.count_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (bus.pos_valid !== 1'b1 || bus.pos_out !== 4'(exp_pos[i])) begin
        n_fail++;
        $display("FAIL sparse_pos%0d got pos=%0d pv=%0b want %0d 1",
                 i, bus.pos_out, bus.pos_valid, exp_pos[i]);
      end
      tick();
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sparse_done got d=%0b pv=%0b want 1 0",
               bus.done, bus.pos_valid);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b0 || bus.mask_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_idle got d=%0b rdy=%0b want 0 1",
               bus.done, bus.mask_ready);
    end
  endtask

  task automatic test_backpressure();
    bus.pos_ready = 1'b0;
    bus.mask_in = 16'h0003;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (bus.pos_valid !== 1'b1 || bus.pos_out !== 4'd1 ||
          bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got pos=%0d pv=%0b d=%0b want 1 1 0",
                 i, bus.pos_out, bus.pos_valid, bus.done);
      end
      tick();
    end
    bus.pos_ready = 1'b1;
    n_chk++;
    if (bus.pos_out !== 4'd1 || bus.pos_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first got pos=%0d pv=%0b want 1 1",
               bus.pos_out, bus.pos_valid);
    end
    tick();
    n_chk++;
    if (bus.pos_out !== 4'd0 || bus.pos_valid !== 1'b1 ||
        bus.match_count !== 5'd2) begin
      n_fail++;
      $display("FAIL bp_second got pos=%0d pv=%0b cnt=%0d want 0 1 2",
               bus.pos_out, bus.pos_valid, bus.match_count);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b1 || bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done got d=%0b pv=%0b want 1 0",
               bus.done, bus.pos_valid);
    end
    tick();
  endtask

  task automatic test_full();
    bus.pos_ready = 1'b1;
    bus.mask_in = 16'hFFFF;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.match_count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_count got %0d want 16", bus.match_count);
    end
    for (int i = 15; i >= 0; i--) begin
      n_chk++;
      if (bus.pos_valid !== 1'b1 || bus.pos_out !== 4'(i)) begin
        n_fail++;
        $display("FAIL full_pos got pos=%0d pv=%0b want %0d 1",
                 bus.pos_out, bus.pos_valid, i);
      end
      tick();
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done got d=%0b pv=%0b want 1 0",
               bus.done, bus.pos_valid);
    end
    tick();
  endtask

  task automatic test_overrun();
    int exp_pos[4] = '{15, 10, 5, 0};
    bus.pos_ready = 1'b1;
    n_chk++;
    if (bus.drop !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pre_drop got %0b want 0", bus.drop);
    end
    bus.mask_in = 16'h8421;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        bus.mask_in = 16'h0001;
        bus.mask_valid = 1'b1;
      end else begin
        bus.mask_valid = 1'b0;
      end
      n_chk++;
      if (bus.pos_valid !== 1'b1 || bus.pos_out !== 4'(exp_pos[i])) begin
        n_fail++;
        $display("FAIL ovr_pos%0d got pos=%0d pv=%0b want %0d 1",
                 i, bus.pos_out, bus.pos_valid, exp_pos[i]);
      end
      tick();
      n_chk++;
      if (bus.drop !== 1'b1) begin
        n_fail++;
        $display("FAIL ovr_drop%0d got %0b want 1", i, bus.drop);
      end
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.match_count !== 5'd4) begin
      n_fail++;
      $display("FAIL ovr_done got d=%0b cnt=%0d want 1 4",
               bus.done, bus.match_count);
    end
    tick();
    tick();
    n_chk++;
    if (bus.drop !== 1'b1 || bus.mask_ready !== 1'b1 ||
        bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_sticky got dr=%0b rdy=%0b pv=%0b want 1 1 0",
               bus.drop, bus.mask_ready, bus.pos_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.pos_ready = 1'b1;
    bus.mask_in = 16'h8421;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    tick();
    tick();
    tick();
    n_chk++;
    if (bus.pos_out !== 4'd5 || bus.pos_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre got pos=%0d pv=%0b want 5 1",
               bus.pos_out, bus.pos_valid);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.mask_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rdy_in_rst got %0b want 0", bus.mask_ready);
    end
    tick();
    reset = 1'b0;
    n_chk++;
    if ({bus.pos_out, bus.pos_valid, bus.match_count,
         bus.count_valid, bus.done, bus.drop} !== 12'h0) begin
      n_fail++;
      $display("FAIL mid_cleared got pos=%0d pv=%0b cnt=%0d cv=%0b d=%0b dr=%0b want all 0",
               bus.pos_out, bus.pos_valid, bus.match_count,
               bus.count_valid, bus.done, bus.drop);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b0 || bus.pos_valid !== 1'b0 ||
        bus.mask_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_quiet got d=%0b pv=%0b rdy=%0b want 0 0 1",
               bus.done, bus.pos_valid, bus.mask_ready);
    end
    bus.mask_in = 16'h0100;
    bus.mask_valid = 1'b1;
    tick();
    bus.mask_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.pos_out !== 4'd8 || bus.pos_valid !== 1'b1 ||
        bus.match_count !== 5'd1) begin
      n_fail++;
      $display("FAIL mid_next got pos=%0d pv=%0b cnt=%0d want 8 1 1",
               bus.pos_out, bus.pos_valid, bus.match_count);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b1 || bus.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_next_done got d=%0b pv=%0b want 1 0",
               bus.done, bus.pos_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sparse();
    test_backpressure();
    test_full();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
